// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends a start bit, 8 data bits,
// odd parity and stop, then waits for the device ACK and bus idle.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | both lines released, waiting for start
// S_INHIBIT | clock held low for INHIBIT ce ticks
// S_REQ     | clock and data low (start bit) for one ce tick
// S_SEND    | clock released; data bits, parity, stop shifted on each fall
// S_ACK     | waiting for the 11th fall to sample the device ACK
// S_WAIT    | waiting for clock and data both high before signalling done
module ps2_host_tx #(
  parameter int INHIBIT = 128,
  parameter int TIMEOUT = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ps2c_low,
  output logic       ps2d_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IW = $clog2(INHIBIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      ps2f_q, ps2f_d;
  logic            pc_q, pc_d;
  logic            pd_q, pd_d;
  logic            fall;
  logic [7:0]      sh_q, sh_d;
  logic            par_q, par_d;
  logic [3:0]      k_q, k_d;
  logic [IW-1:0]   inh_q, inh_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            cl_q, cl_d;
  logic            dl_q, dl_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            timed_out;

  // Glitch filter: clean clock level needs 8 identical ce samples to change.
  always_comb begin
    ps2f_d = ps2f_q;
    pc_d   = pc_q;
    pd_d   = pd_q;
    fall   = 1'b0;
    if (ce) begin
      ps2f_d = {ps2f_q[6:0], ps2[0]};
      pd_d   = ps2[1];
      if (&ps2f_d)
        pc_d = 1'b1;
      else if (ps2f_d == 8'h00)
        pc_d = 1'b0;
      fall = pc_q & ~pc_d;
    end
  end

  assign timed_out = ce && !fall && (tmo_q == '0);

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    par_d   = par_q;
    k_d     = k_q;
    inh_d   = inh_q;
    tmo_d   = tmo_q;
    cl_d    = cl_q;
    dl_d    = dl_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cl_d = 1'b0;
        dl_d = 1'b0;
        if (start) begin
          sh_d    = data;
          par_d   = ~^data;
          k_d     = '0;
          inh_d   = INH_LOAD;
          tmo_d   = TMO_LOAD;
          cl_d    = 1'b1;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (ce) begin
          if (inh_q == '0) begin
            dl_d    = 1'b1;
            state_d = S_REQ;
          end else begin
            inh_d = inh_q - 1'b1;
          end
        end
      end
      S_REQ: begin
        if (ce) begin
          cl_d    = 1'b0;
          k_d     = '0;
          tmo_d   = TMO_LOAD;
          state_d = S_SEND;
        end
      end
      S_SEND, S_ACK, S_WAIT: begin
        if (fall)
          tmo_d = TMO_LOAD;
        else if (ce && tmo_q != '0)
          tmo_d = tmo_q - 1'b1;

        if (timed_out) begin
          err_d   = 1'b1;
          cl_d    = 1'b0;
          dl_d    = 1'b0;
          state_d = S_IDLE;
        end else if (state_q == S_SEND) begin
          if (fall) begin
            k_d = k_q + 4'd1;
            if (k_q < 4'd8) begin
              dl_d = ~sh_q[k_q[2:0]];
            end else if (k_q == 4'd8) begin
              dl_d = ~par_q;
            end else begin
              dl_d    = 1'b0;
              state_d = S_ACK;
            end
          end
        end else if (state_q == S_ACK) begin
          if (fall) begin
            if (!pd_q) begin
              state_d = S_WAIT;
            end else begin
              err_d   = 1'b1;
              dl_d    = 1'b0;
              state_d = S_IDLE;
            end
          end
        end else begin
          if (ce && pc_q && pd_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cl_d    = 1'b0;
        dl_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ps2f_q  <= 8'hFF;
      pc_q    <= 1'b1;
      pd_q    <= 1'b1;
      sh_q    <= '0;
      par_q   <= 1'b0;
      k_q     <= '0;
      inh_q   <= '0;
      tmo_q   <= '0;
      cl_q    <= 1'b0;
      dl_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ps2f_q  <= ps2f_d;
      pc_q    <= pc_d;
      pd_q    <= pd_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      k_q     <= k_d;
      inh_q   <= inh_d;
      tmo_q   <= tmo_d;
      cl_q    <= cl_d;
      dl_q    <= dl_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ps2c_low = cl_q;
  assign ps2d_low = dl_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign error    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the host and records
// what it would sample; expected line levels come from the byte and its parity.
module tb_ps2_host_tx;

  localparam int INH  = 128;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic       start;
  logic [7:0] data;
  logic [1:0] ps2;
  logic       ps2c_low, ps2d_low, busy, done, error;
  logic       dev_c, dev_d;

  int total = 0;
  int passed = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  // Open-collector bus: either side can pull a line low.
  assign ps2 = {dev_d & ~ps2d_low, dev_c & ~ps2c_low};

  ps2_host_tx #(.INHIBIT(INH), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ce(ce), .ps2(ps2), .start(start), .data(data),
    .ps2c_low(ps2c_low), .ps2d_low(ps2d_low), .busy(busy), .done(done), .error(error)
  );

  always @(negedge clock) begin
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
  end

  typedef struct {
    logic [7:0]  d;
    bit          ack;
    logic [10:0] exp_obs;
    bit          exp_done;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ps2d_low the device should see at each of the 11 rising edges.
  function automatic logic [10:0] model(input logic [7:0] d);
    logic [10:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = (d[i] == 1'b0);
    m[8] = ($countones(d) % 2) == 1;
    return m;
  endfunction

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clock);
    data  = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic dev_frame(input bit ack_ok, output logic [10:0] obs, output bit ok);
    int n;
    obs = '0;
    ok  = 1'b1;
    n = 0;
    while (ps2c_low !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    n = 0;
    while (ps2c_low !== 1'b0 && n < 1000) begin @(negedge clock); n++; end
    if (n >= 1000) begin
      ok = 1'b0;
      return;
    end
    repeat (HALF) @(negedge clock);
    for (int e = 0; e < 11; e++) begin
      if (e == 10 && ack_ok) dev_d = 1'b0;
      dev_c = 1'b0;
      repeat (HALF) @(negedge clock);
      obs[e] = ps2d_low;
      dev_c = 1'b1;
      repeat (HALF) @(negedge clock);
    end
    dev_d = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit ack_ok,
                           input logic [10:0] exp_obs, input bit exp_done, input bit extra_start);
    int d0, e0, n;
    logic [10:0] obs;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(d);
    if (extra_start) begin
      repeat (10) @(negedge clock);
      data  = 8'h55;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    dev_frame(ack_ok, obs, ok);
    chk({tag, "_release"}, int'(ok), 1);
    n = 0;
    while (busy && n < 200) begin @(negedge clock); n++; end
    repeat (2) @(negedge clock);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_bits"}, int'(obs), int'(exp_obs));
    chk({tag, "_done"}, done_cnt - d0, int'(exp_done));
    chk({tag, "_error"}, err_cnt - e0, int'(!exp_done));
    chk({tag, "_lines"}, int'({ps2c_low, ps2d_low}), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, n_cl, n_dl0, d0, e0;
    logic [7:0] rd;
    bit ra;

    vt[0] = '{8'hED, 1'b1, 11'h012, 1'b1};
    vt[1] = '{8'h00, 1'b1, 11'h0FF, 1'b1};
    vt[2] = '{8'hFF, 1'b1, 11'h000, 1'b1};
    vt[3] = '{8'h01, 1'b1, 11'h1FE, 1'b1};
    vt[4] = '{8'hAA, 1'b0, 11'h055, 1'b0};

    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    dev_c = 1'b1;
    dev_d = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_ps2c_low", int'(ps2c_low), 0);
    chk("rst_ps2d_low", int'(ps2d_low), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int i = 0; i < 5; i++)
      run_frame($sformatf("vec%0d", i), vt[i].d, vt[i].ack, vt[i].exp_obs, vt[i].exp_done, 1'b0);

    // Inhibit length, start bit, then a device that never clocks.
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'hA5);
    chk("inh_busy", int'(busy), 1);
    n_cl = 0;
    n_dl0 = 0;
    while (ps2c_low && n_cl < 1000) begin
      n_cl++;
      if (!ps2d_low) n_dl0++;
      @(negedge clock);
    end
    chk("inh_clk_low_ticks", n_cl, INH + 1);
    chk("inh_data_rise_tick", n_dl0, INH);
    chk("inh_data_held", int'(ps2d_low), 1);
    n = 0;
    while (!error && n < TMO + 50) begin @(negedge clock); n++; end
    chk("tmo_ticks", n, TMO);
    chk("tmo_lines", int'({ps2c_low, ps2d_low}), 0);
    chk("tmo_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    chk("tmo_error_cnt", err_cnt - e0, 1);
    chk("tmo_done_cnt", done_cnt - d0, 0);

    run_frame("busy_start", 8'hED, 1'b1, model(8'hED), 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d_%02h", i, rd), rd, ra, model(rd), ra, 1'b0);
    end

    // Reset in the middle of the frame, after the fifth data edge.
    pulse_start(8'h0F);
    n = 0;
    while (ps2c_low !== 1'b0 && n < 1000) begin @(negedge clock); n++; end
    repeat (HALF) @(negedge clock);
    for (int e = 0; e < 5; e++) begin
      dev_c = 1'b0;
      repeat (HALF) @(negedge clock);
      if (e < 4) begin
        dev_c = 1'b1;
        repeat (HALF) @(negedge clock);
      end
    end
    chk("midrst_k5_data", int'(ps2d_low), 1);
    d0 = done_cnt;
    e0 = err_cnt;
    reset = 1'b0;
    #1;
    chk("midrst_ps2c_low", int'(ps2c_low), 0);
    chk("midrst_ps2d_low", int'(ps2d_low), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    dev_c = 1'b1;
    repeat (50) @(negedge clock);
    chk("midrst_done_cnt", done_cnt - d0, 0);
    chk("midrst_error_cnt", err_cnt - e0, 0);
    chk("midrst_idle", int'(busy), 0);

    run_frame("after_rst", 8'h3C, 1'b1, model(8'h3C), 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter that sends command bytes to the keyboard, such as 0xED/LED-state or 0xFF reset. It shares the PS/2 clock/data lines with the `keyboard` receiver. It drives the open-collector lines through pull-low enables and runs the full host request sequence: inhibit, start, 8 data bits, odd parity, stop and device ACK. The device's reply byte (0xFA) is decoded by `keyboard` as a normal scancode.

## Interface
Parameters:
- `INHIBIT`, default 128: ce ticks the clock is held low before the start bit (≥100 µs at 1 MHz ce).
- `TIMEOUT`, default 20000: ce ticks allowed between consecutive device clock falling edges before abort.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ce`  in  1  sample/step enable, same strobe as `keyboard`; nominal 1 MHz.
- `ps2`  in  2  raw line levels; `[0]` = PS/2 clock, `[1]` = PS/2 data.
- `start`  in  1  request; accepted on any `clock` edge while `busy`=0.
- `data`  in  8  byte to send; captured when `start` is accepted.
- `ps2c_low`  out  1  1 = pull PS/2 clock low; 0 = release.
- `ps2d_low`  out  1  1 = pull PS/2 data low; 0 = release.
- `busy`  out  1  high from the cycle after acceptance until `done`/`error`.
- `done`  out  1  one-`clock` pulse: byte sent and ACK received.
- `error`  out  1  one-`clock` pulse: missing ACK or timeout.

## Operation
- **Line filter**, on ce: `ps2f` is an 8-bit shift register of `ps2[0]`.
  - Clean level `pc` sets on all-ones and clears on all-zeros.
  - `fall` is asserted for one ce tick when `pc` goes 1→0.
  - `pd` is a register of `ps2[1]` on ce.
- **States:** IDLE, INHIBIT, REQ, SEND, ACK, WAIT.
  - **IDLE:** both lines released. `start` latches `data` into `sh`, computes `par = ~^data` (odd parity), clears counters and moves to INHIBIT.
  - **INHIBIT:** `ps2c_low`=1. After `INHIBIT` ce ticks, sets `ps2d_low`=1 (start bit) and moves to REQ.
  - **REQ:** holds both low for 1 ce tick, then releases the clock (`ps2c_low`=0), clears the bit count `k` and timeout, and moves to SEND.
  - **SEND:** on each `fall`, increments `k` and clears the timeout.
    - k=1..8: `ps2d_low` = ~`sh[k-1]`.
    - k=9: `ps2d_low` = ~`par`.
    - k=10: `ps2d_low`=0 (stop bit), then move to ACK.
  - **ACK:** on the next `fall`, sample `pd`. `pd`=0 → WAIT; `pd`=1 → `error`, IDLE.
  - **WAIT:** when `pc`=1 and `pd`=1 on a ce tick → `done`, IDLE.
- **Timeout:** in SEND, ACK and WAIT a ce-tick counter runs, cleared on every `fall`. Reaching `TIMEOUT` → `error`, both lines released, IDLE. Counter width is clog2(`TIMEOUT`+1).
- `busy` = (state ≠ IDLE). It falls in the same cycle `done`/`error` pulses, so a `start` in that cycle is accepted.
- `start` while `busy`=1 is ignored; `data` is not re-captured.
- `done` and `error` never assert together; exactly one fires per accepted `start`.

## Timing
- **Reset values:** every output 0, state IDLE, `pc`=1, filter = 8'hFF.
  - Reset mid-frame releases both lines combinationally from the cleared registers, with no `done`/`error` pulse.
- **Start to first edge:**
  - `start` accepted at cycle t; `busy`=1 and `ps2c_low`=1 from t+1.
  - `ps2d_low` rises after `INHIBIT` ce ticks.
  - `ps2c_low` falls 1 ce tick later, so the clock is held low for exactly `INHIBIT`+1 ce ticks.
- **Filter latency:** `fall` is flagged 8 ce ticks after the physical falling edge.
  - ce must be ≥ 8 ticks per ~30 µs device low phase, i.e. ≥ ~270 kHz; 1 MHz is nominal.
  - Data changes therefore land mid-low-phase, before the device samples on the rising edge.
- **After REQ:** the device clock must return high (`pc`=1, 8 high samples) before the first `fall` counts.

## Test plan
- **Send 0xED, device model ACKs:** `ps2d_low` per falling edge = 0,1,0,0,1,0,0,0, parity 0, stop 0; ACK sampled 0; one `done`, no `error`; `busy` returns 0.
- **Send 0x00:** data-bit `ps2d_low` all 1, parity edge `ps2d_low`=0, stop 0; `done`.
- **INHIBIT=128:** `ps2c_low` high for exactly 129 ce ticks; `ps2d_low` rises at tick 128 and stays high through release.
- **Device leaves data high at the 11th edge:** one `error` pulse, no `done`; both lines 0 in the following cycle.
- **Device never clocks after release:** `error` exactly `TIMEOUT` ce ticks after `ps2c_low` falls; lines released.
- **Start while busy, and reset mid-frame:**
  - A second `start` with 0x55 mid-frame is ignored; the frame still carries the first byte.
  - Asserting `reset` at k=5 drives both outputs and `busy` to 0 with no `done`/`error` pulse.
